pll_reset_sequencer: RTL
========================

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 50: cycles pll_rst is held high per PLL reset pulse (1 us at 50 MHz).
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1000: consecutive synchronized-locked cycles required before release.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 50000: maximum cycles spent in WAIT_LOCK before a retry.
REQ-004 SHALL have parameter STAGGER_CYCLES, default 16: spacing between successive domain reset releases.
REQ-005 SHALL have parameter N_DOMAINS, default 3: number of downstream reset outputs.
REQ-006 SHALL have port refclk, input, 1 bit: the single clock, 50 MHz board reference.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port locked, input, 1 bit: PLL lock indication, asynchronous to refclk.
REQ-009 SHALL have port force_relock, input, 1 bit: single-cycle request to restart the PLL.
REQ-010 SHALL have port pll_rst, output, 1 bit: reset to the PLL, active-high.
REQ-011 SHALL have port domain_rst, output, N_DOMAINS bits: per-domain active-high resets.
REQ-012 SHALL have port ready, output, 1 bit: high only when all domains are released and the PLL is locked.
REQ-013 SHALL have port lock_loss_cnt, output, 8 bits: saturating count of lock losses after first release.
REQ-014 SHALL have port retry_cnt, output, 8 bits: saturating count of WAIT_LOCK timeouts.

Function
REQ-015 SHALL synchronize locked through two refclk flops into locked_s; all decisions SHALL use locked_s only.
REQ-016 SHALL implement states PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN, driven by one shared down/up cycle counter.
REQ-017 PLL_RST: pll_rst=1 and all domain_rst=1; after PLL_RST_CYCLES cycles SHALL go to WAIT_LOCK.
REQ-018 WAIT_LOCK: pll_rst=0; locked_s=1 SHALL go to STABLE; after LOCK_TIMEOUT_CYCLES cycles without lock SHALL go to PLL_RST and increment retry_cnt.
REQ-019 STABLE: locked_s=0 SHALL return to WAIT_LOCK with a fresh timeout count; LOCK_STABLE_CYCLES consecutive locked_s=1 cycles SHALL go to RELEASE.
REQ-020 RELEASE: domain_rst[0] SHALL clear on entry and domain_rst[i] SHALL clear STAGGER_CYCLES after domain_rst[i-1]; go to RUN on the cycle the last bit clears.
REQ-021 RUN: ready=1 and all domain_rst=0.
REQ-022 locked_s=0 in RELEASE or RUN SHALL go to PLL_RST, set all domain_rst=1 and ready=0 on the same edge, and increment lock_loss_cnt.
REQ-023 force_relock=1 in any state except PLL_RST SHALL go to PLL_RST without incrementing any counter; force_relock SHALL take priority over simultaneous lock loss.
REQ-024 Both counters SHALL saturate at 255 and never wrap.
REQ-025 All outputs SHALL be registered and change on the same edge as the state register; latency from the first edge sampling locked=0 to domain_rst=all-ones SHALL be exactly 3 edges.

Reset
REQ-026 rst=1 SHALL force state PLL_RST, pll_rst=1, domain_rst=all-ones, ready=0, both counters=0, synchronizer flops=0, and cycle counter=0, regardless of the current state.
REQ-027 After rst deasserts, the PLL_RST pulse SHALL last the full PLL_RST_CYCLES.

Structure
REQ-028 Package pll_seq_pkg SHALL hold the state enumeration and the counter-width constant, computed as clog2 of the largest cycle parameter plus 1.
REQ-029 The two-flop synchronizer SHALL be a sub-module named sync_2ff; all else SHALL live in pll_reset_sequencer.

Verification (PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, STAGGER_CYCLES=2, N_DOMAINS=3)
REQ-030 Power-up: rst for 2 cycles, locked=1 from cycle 10 -> pll_rst high for 4 cycles; domain_rst walks 3'b110, 3'b100, 3'b000 at 2-cycle spacing; ready=1.
REQ-031 Timeout: locked held 0 -> pll_rst re-pulses every 36 cycles; retry_cnt is 1, 2, 3.
REQ-032 Glitch in STABLE: locked low 1 cycle at stable count 5 -> state returns to WAIT_LOCK, no release, lock_loss_cnt stays 0.
REQ-033 Loss in RUN: locked falls -> domain_rst=3'b111 and ready=0 exactly 3 edges later; lock_loss_cnt=1; full sequence repeats.
REQ-034 force_relock and lock loss on the same cycle in RUN -> PLL_RST entered, lock_loss_cnt unchanged.
REQ-035 Saturation and reset: 260 induced losses -> lock_loss_cnt=255; rst asserted mid-RELEASE -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// Holds the state encoding, status counter width and counter sizing.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RELEASE,
    ST_RUN
  } state_t;

  localparam int STAT_W = 8;

  localparam int DEF_PLL_RST_CYCLES      = 50;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1000;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int DEF_STAGGER_CYCLES      = 16;

  function automatic int cnt_width(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

  localparam int CNT_W = cnt_width(
    DEF_PLL_RST_CYCLES, DEF_LOCK_STABLE_CYCLES,
    DEF_LOCK_TIMEOUT_CYCLES, DEF_STAGGER_CYCLES);

  function automatic logic [STAT_W-1:0] sat_inc(
    input logic [STAT_W-1:0] v
  );
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the sequencer and its environment.
// master drives lock/relock and observes resets and status.
interface pll_reset_sequencer_if
  import pll_seq_pkg::*;
#(
  parameter int N_DOMAINS = 3
);
  logic                 locked;
  logic                 force_relock;
  logic                 pll_rst;
  logic [N_DOMAINS-1:0] domain_rst;
  logic                 ready;
  logic [STAT_W-1:0]    lock_loss_cnt;
  logic [STAT_W-1:0]    retry_cnt;

  modport master (
    output locked, force_relock,
    input  pll_rst, domain_rst, ready,
    input  lock_loss_cnt, retry_cnt
  );

  modport slave (
    input  locked, force_relock,
    output pll_rst, domain_rst, ready,
    output lock_loss_cnt, retry_cnt
  );
endinterface

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Both stages clear on the synchronous reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;
endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock qualification and staggered domain reset release.
// One shared cycle counter times every state; all outputs registered.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 50,
  parameter int LOCK_STABLE_CYCLES  = 1000,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int STAGGER_CYCLES      = 16,
  parameter int N_DOMAINS           = 3
) (
  input  logic                 refclk,
  input  logic                 rst,
  input  logic                 locked,
  input  logic                 force_relock,
  output logic                 pll_rst,
  output logic [N_DOMAINS-1:0] domain_rst,
  output logic                 ready,
  output logic [STAT_W-1:0]    lock_loss_cnt,
  output logic [STAT_W-1:0]    retry_cnt
);
  localparam int CW = cnt_width(
    PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
    LOCK_TIMEOUT_CYCLES, STAGGER_CYCLES);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t PLL_LAST = cnt_t'(PLL_RST_CYCLES - 1);
  localparam cnt_t STB_LAST = cnt_t'(LOCK_STABLE_CYCLES - 1);
  localparam cnt_t TO_LAST  = cnt_t'(LOCK_TIMEOUT_CYCLES - 1);
  localparam cnt_t STG_LAST = cnt_t'(STAGGER_CYCLES - 1);

  logic locked_s;

  sync_2ff u_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  state_t               state_q;
  cnt_t                 cnt_q;
  logic                 pll_rst_q;
  logic [N_DOMAINS-1:0] dom_q;
  logic                 ready_q;
  logic [STAT_W-1:0]    loss_q;
  logic [STAT_W-1:0]    retry_q;

  logic                 relock;
  logic                 lost;
  logic [N_DOMAINS-1:0] dom_shift;

  // Domains release from bit 0 upward, one bit per shift.
  assign dom_shift = dom_q << 1;
  assign relock = force_relock && (state_q != ST_PLL_RST);
  assign lost   = !locked_s &&
                  (state_q == ST_RELEASE || state_q == ST_RUN);

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= ST_PLL_RST;
      cnt_q     <= '0;
      pll_rst_q <= 1'b1;
      dom_q     <= '1;
      ready_q   <= 1'b0;
      loss_q    <= '0;
      retry_q   <= '0;
    end else if (relock || lost) begin
      state_q   <= ST_PLL_RST;
      cnt_q     <= '0;
      pll_rst_q <= 1'b1;
      dom_q     <= '1;
      ready_q   <= 1'b0;
      // A requested relock is not a lock loss.
      if (!relock) loss_q <= sat_inc(loss_q);
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == PLL_LAST) begin
            state_q   <= ST_WAIT_LOCK;
            cnt_q     <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + cnt_t'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == TO_LAST) begin
            state_q   <= ST_PLL_RST;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            retry_q   <= sat_inc(retry_q);
          end else begin
            cnt_q <= cnt_q + cnt_t'(1);
          end
        end
        ST_STABLE: begin
          if (!locked_s) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == STB_LAST) begin
            cnt_q <= '0;
            dom_q <= dom_shift;
            if (dom_shift == '0) begin
              state_q <= ST_RUN;
              ready_q <= 1'b1;
            end else begin
              state_q <= ST_RELEASE;
            end
          end else begin
            cnt_q <= cnt_q + cnt_t'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt_q == STG_LAST) begin
            cnt_q <= '0;
            dom_q <= dom_shift;
            if (dom_shift == '0) begin
              state_q <= ST_RUN;
              ready_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + cnt_t'(1);
          end
        end
        ST_RUN: begin
          ready_q <= 1'b1;
          dom_q   <= '0;
        end
        default: begin
          state_q   <= ST_PLL_RST;
          cnt_q     <= '0;
          pll_rst_q <= 1'b1;
          dom_q     <= '1;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst       = pll_rst_q;
  assign domain_rst    = dom_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = loss_q;
  assign retry_cnt     = retry_q;
endmodule
